// File: rtl/irq_controller_if.sv
// Memory-mapped bus seen by the interrupt controller. BUS_DATA is the shared
// data wire: the controller drives it during reads, the bus master during writes.
interface irq_controller_if;
  wire  [7:0] BUS_DATA;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] rd_data;
  logic       rd_en;
  logic [7:0] wr_data;
  logic       wr_en;

  // Bus resolution: an undriven bus floats.
  assign BUS_DATA = rd_en ? rd_data : (wr_en ? wr_data : 8'hzz);

  // Handshake: a write completes on the CLK edge where BUS_WE=1 and BUS_ADDR
  // matches; a read address registered on one edge is answered by rd_en=1
  // for the whole following cycle, with no stall or ready signal.
  modport slave  (input BUS_DATA, BUS_ADDR, BUS_WE, output rd_data, rd_en);
  modport master (input BUS_DATA, rd_en, output BUS_ADDR, BUS_WE, wr_data, wr_en);
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: edge-captured pending bits, a writable
// mask, one request at a time to the CPU, and a one-cycle ack to the peripheral.
module irq_controller #(
  parameter logic [7:0] IrqBaseAddr = 8'hE0,
  parameter logic [3:0] InitialMask = 4'hF
) (
  input  logic                CLK,
  input  logic                RESET_N,
  irq_controller_if.slave     bus,
  input  logic [3:0]          SRC_RAISE,
  output logic [3:0]          SRC_ACK,
  output logic                CPU_IRQ_RAISE,
  input  logic                CPU_IRQ_ACK,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] AddrStatus = IrqBaseAddr;
  localparam logic [7:0] AddrMask   = IrqBaseAddr + 8'd1;
  localparam logic [7:0] AddrClear  = IrqBaseAddr + 8'd2;

  state_t     state, state_n;
  logic [1:0] active_idx, active_n;
  logic       raise_n;
  logic [3:0] ack_n;
  logic       grant;
  logic [3:0] pending, mask, raise_prev;
  logic [3:0] rise_edge, clr, enabled;
  logic [1:0] first_idx;
  logic       rd_en_q;
  logic [1:0] rd_sel;
  logic       wr_mask, wr_clear, rd_hit;

  wire unused_bus_bits = &{1'b0, bus.BUS_DATA[7:4]};

  assign dbg_state = state;
  assign wr_mask   = bus.BUS_WE && (bus.BUS_ADDR == AddrMask);
  assign wr_clear  = bus.BUS_WE && (bus.BUS_ADDR == AddrClear);
  assign rd_hit    = !bus.BUS_WE && ((bus.BUS_ADDR == AddrStatus) ||
                     (bus.BUS_ADDR == AddrMask) || (bus.BUS_ADDR == AddrClear));

  assign rise_edge = SRC_RAISE & ~raise_prev;
  assign enabled   = pending & mask;
  assign clr       = (wr_clear ? bus.BUS_DATA[3:0] : 4'b0000) |
                     (grant ? (4'b0001 << active_idx) : 4'b0000);

  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (enabled[i]) first_idx = i[1:0];
    end
  end

  always_comb begin
    state_n  = state;
    active_n = active_idx;
    raise_n  = CPU_IRQ_RAISE;
    ack_n    = 4'b0000;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (|enabled) begin
          active_n = first_idx;
          raise_n  = 1'b1;
          state_n  = REQ;
        end
      end
      // Committed: mask or bus clear cannot withdraw the request from here.
      REQ: begin
        raise_n = 1'b1;
        if (CPU_IRQ_ACK) begin
          ack_n   = 4'b0001 << active_idx;
          grant   = 1'b1;
          raise_n = 1'b0;
          state_n = GAP;
        end
      end
      // Dead cycle; the active index returns to 0 so status reads idle cleanly.
      GAP: begin
        active_n = 2'd0;
        state_n  = IDLE;
      end
      default: begin
        raise_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      active_idx    <= 2'd0;
      CPU_IRQ_RAISE <= 1'b0;
      SRC_ACK       <= 4'b0000;
      pending       <= 4'b0000;
      mask          <= InitialMask;
      raise_prev    <= 4'b0000;
      rd_en_q       <= 1'b0;
      rd_sel        <= 2'd0;
    end else begin
      state         <= state_n;
      active_idx    <= active_n;
      CPU_IRQ_RAISE <= raise_n;
      SRC_ACK       <= ack_n;
      // A fresh edge wins over any clear of the same bit.
      pending       <= (pending & ~clr) | rise_edge;
      raise_prev    <= SRC_RAISE;
      if (wr_mask) mask <= bus.BUS_DATA[3:0];
      rd_en_q       <= rd_hit;
      rd_sel        <= (bus.BUS_ADDR == AddrMask)  ? 2'd1 :
                       (bus.BUS_ADDR == AddrClear) ? 2'd2 : 2'd0;
    end
  end

  always_comb begin
    case (rd_sel)
      2'd0:    bus.rd_data = {state == REQ, 1'b0, active_idx, pending};
      2'd1:    bus.rd_data = {4'b0000, mask};
      default: bus.rd_data = 8'h00;
    endcase
  end

  assign bus.rd_en = rd_en_q;
endmodule
